// File: rtl/aes_host_bridge.sv
// Host-side link for the AES chip pin interface: 32-bit words are sent as 4 strobed bytes on chip_rx,
// and strobed bytes from chip_tx are gathered into 32-bit words and queued in a show-ahead FIFO.
module aes_host_bridge #(
  parameter int GAP_CYCLES = 3,
  parameter int RX_DEPTH   = 4,
  parameter int RX_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] host_wdata,
  input  logic        host_wvalid,
  output logic        host_wready,
  output logic [8:0]  chip_rx,
  input  logic [8:0]  chip_tx,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  input  logic        host_rready,
  output logic        rx_overflow,
  output logic        rx_timeout,
  output logic [1:0]  tx_state_dbg
);

  // Handshakes: a word moves host->bridge in any cycle where host_wvalid and host_wready are both
  // high, and bridge->host in any cycle where host_rvalid and host_rready are both high.

  localparam int AW = $clog2(RX_DEPTH);
  localparam int TW = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

  tx_state_e   state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic [8:0]  chip_rx_q, chip_rx_d;
  logic        wready_q, wready_d;
  logic        byte_done;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    chip_rx_d = chip_rx_q;
    wready_d  = wready_q;
    byte_done = 1'b0;
    case (state_q)
      TX_IDLE: begin
        chip_rx_d = 9'h000;
        if (host_wvalid && wready_q) begin
          state_d   = TX_SEND;
          word_d    = host_wdata;
          idx_d     = 2'd0;
          chip_rx_d = {1'b1, host_wdata[31:24]};
          wready_d  = 1'b0;
        end
      end
      TX_SEND: begin
        if (GAP_CYCLES == 0) begin
          byte_done = 1'b1;
        end else begin
          state_d   = TX_GAP;
          gap_d     = 4'(GAP_CYCLES - 1);
          chip_rx_d = {1'b0, chip_rx_q[7:0]};
        end
      end
      TX_GAP: begin
        if (gap_q == 4'd0) byte_done = 1'b1;
        else               gap_d = gap_q - 4'd1;
      end
      default: begin
        state_d   = TX_IDLE;
        chip_rx_d = 9'h000;
        wready_d  = 1'b1;
      end
    endcase
    // The byte on the pins is always word_q[31:24]; shifting exposes the next one.
    if (byte_done) begin
      if (idx_q == 2'd3) begin
        state_d   = TX_IDLE;
        chip_rx_d = 9'h000;
        wready_d  = 1'b1;
      end else begin
        state_d   = TX_SEND;
        idx_d     = idx_q + 2'd1;
        word_d    = {word_q[23:0], 8'h00};
        chip_rx_d = {1'b1, word_q[23:16]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= TX_IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      chip_rx_q <= '0;
      wready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      chip_rx_q <= chip_rx_d;
      wready_q  <= wready_d;
    end
  end

  assign host_wready  = wready_q;
  assign chip_rx      = chip_rx_q;
  assign tx_state_dbg = state_q;

  logic [8:0]    pin_q;
  logic [31:0]   asm_q, asm_d, asm_base, asm_next;
  logic [1:0]    cnt_q, cnt_d, cnt_base;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit, tmo_pulse_q, tmo_pulse_d;
  logic          push;
  logic [31:0]   push_word;

  always_comb begin
    tmo_hit     = (cnt_q != 2'd0) && (tmo_q == TW'(RX_TIMEOUT));
    tmo_pulse_d = tmo_hit;
    asm_base    = tmo_hit ? 32'h0 : asm_q;
    cnt_base    = tmo_hit ? 2'd0 : cnt_q;
    asm_next    = {asm_base[23:0], pin_q[7:0]};
    asm_d       = asm_base;
    cnt_d       = cnt_base;
    push        = 1'b0;
    push_word   = asm_next;
    tmo_d       = tmo_q;
    if (pin_q[8]) begin
      tmo_d = '0;
      if (cnt_base == 2'd3) begin
        push  = 1'b1;
        asm_d = 32'h0;
        cnt_d = 2'd0;
      end else begin
        asm_d = asm_next;
        cnt_d = cnt_base + 2'd1;
      end
    end else if (tmo_hit) begin
      tmo_d = '0;
    end else if (cnt_q != 2'd0) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  logic [31:0] mem_q [RX_DEPTH];
  logic [31:0] mem_d [RX_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        ovf_q, ovf_d;
  logic        fifo_empty, fifo_full, pop, wr_en;

  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop        = !fifo_empty && host_rready;
    // When full, a simultaneous pop frees the head slot, which is exactly where the write lands.
    wr_en      = push && (!fifo_full || pop);
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ovf_d      = ovf_q | (push && fifo_full && !pop);
    if (wr_en) begin
      mem_d[wptr_q[AW-1:0]] = push_word;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (pop) rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_q       <= '0;
      asm_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pin_q       <= chip_tx;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tmo_pulse_q <= tmo_pulse_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
    end
  end

  assign host_rvalid = !fifo_empty;
  assign host_rdata  = fifo_empty ? 32'h0 : mem_q[rptr_q[AW-1:0]];
  assign rx_overflow = ovf_q;
  assign rx_timeout  = tmo_pulse_q;

endmodule
